multicycle_control_hs: RTL and testbench
========================================

// Module: multicycle_control_hs
// PURPOSE
// Next-generation multicycle control FSM: sequences fetch/decode/execute/memory/writeback for the RV32I multicycle core.
// Adds a ready/valid memory handshake with per-access wait states, a parametrised bus timeout and a trap state (illegal opcode, timeout).
// Sits in the multicycle control path, between the memory interface and the datapath enables; ALU/branch decode stay external.
// PARAMETERS
// TIMEOUT_CYCLES  16  max cycles a memory access may wait for mem_ready; 0 disables timeout
// CNT_W           $clog2(TIMEOUT_CYCLES+1)  wait counter width (derived, do not override)
// PORTS
// clock                  in   1  core clock, all state on rising edge
// reset_n                in   1  asynchronous, active-low reset
// inst_opcode            in   7  opcode of latched instruction register
// take_branch            in   1  branch condition from control_transfer
// mem_ready              in   1  memory completes current access this cycle
// trap_clear             in   1  leave TRAP, restart fetch (debug/irq hook)
// pc_write_enable        out  1  PC register load
// inst_write_enable      out  1  instruction register load
// data_write_enable      out  1  memory data register load
// alu_out_write_enable   out  1  ALU output register load
// regfile_write_enable   out  1  register file write
// mem_read_enable        out  1  memory read request (held until mem_ready)
// mem_write_enable       out  1  memory write request (held until mem_ready)
// inst_or_data           out  1  0=PC addresses memory, 1=ALU out addresses memory
// alu_operand_a_select   out  1  0=rs1, 1=PC
// alu_operand_b_select   out  2  0=rs2, 1=imm, 2=const 4
// alu_op_type            out  2  0=ADD, 1=BRANCH compare, 2=OP, 3=OP-IMM
// reg_writeback_select   out  3  0=ALU out, 1=mem data, 2=imm (LUI), 3=PC+4
// next_pc_select         out  1  0=ALU result, 1=ALU out register
// trap                   out  1  high while in TRAP
// trap_cause             out  2  0=none, 1=illegal opcode, 2=fetch timeout, 3=data timeout
// BEHAVIOUR
// Reset (reset_n=0, async): state=FETCH, wait counter=0, trap_cause=0; all enables 0, all selects 0.
// Enables are Moore-decoded from state except where gated by mem_ready/take_branch; selects default 0.
// FETCH: mem_read_enable=1, inst_or_data=0; on mem_ready: inst_write_enable=1, pc_write_enable=1 (a=PC, b=4, ADD) -> DECODE.
// DECODE: a=PC, b=imm, ADD, alu_out_write_enable=1 (branch/jal target). Next by opcode:
//   0000011/0100011 -> MEM_ADDR; 0110011/0010011/0110111/0010111 -> EXEC; 1100011 -> BRANCH;
//   1101111 -> JAL; 1100111 -> JALR; anything else -> TRAP, trap_cause=1.
// MEM_ADDR: a=rs1, b=imm, ADD, alu_out_write_enable=1 -> MEM_RD (load) or MEM_WR (store).
// MEM_RD: mem_read_enable=1, inst_or_data=1; on mem_ready: data_write_enable=1 -> LOAD_WB.
// MEM_WR: mem_write_enable=1, inst_or_data=1; on mem_ready -> FETCH.
// LOAD_WB: regfile_write_enable=1, writeback=1 -> FETCH.
// EXEC: OP: b=rs2, op=2; OP-IMM: b=imm, op=3; AUIPC: a=PC(old), b=imm, op=0; LUI: no ALU; alu_out_write_enable=1 -> ALU_WB.
// ALU_WB: regfile_write_enable=1; writeback=2 for LUI else 0 -> FETCH.
// BRANCH: op=1 (rs1 vs rs2); pc_write_enable=take_branch, next_pc_select=1 -> FETCH.
// JAL: regfile_write_enable=1, writeback=3, pc_write_enable=1, next_pc_select=1 -> FETCH.
// JALR: a=rs1, b=imm, ADD, regfile_write_enable=1, writeback=3, pc_write_enable=1, next_pc_select=0 -> FETCH.
// Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR and on mem_ready.
//   Increments each cycle request is held without mem_ready.
//   If TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES-1 with no mem_ready: -> TRAP, trap_cause=2 (FETCH) or 3 (MEM_RD/MEM_WR).
// Timeout boundary: mem_ready and timeout in same cycle -> mem_ready wins, access completes. Counter saturates, never wraps.
// TRAP: all enables 0, trap=1, cause held; trap_clear=1 -> FETCH next cycle, cause cleared to 0. PC is not modified.
// Latency: ALU/LUI/AUIPC 4 cycles, load 5, store 4, branch/jal/jalr 3, each plus memory wait cycles (zero-wait: mem_ready in first cycle).
// Reset mid-access drops requests immediately (async) and restarts at FETCH.
// TESTING
// addi, mem_ready tied 1 -> FETCH,DECODE,EXEC,ALU_WB; regfile_write_enable 1 cycle in cycle 4; pc_write_enable in cycle 1.
// lw, data ready after 3 wait cycles -> mem_read_enable held 4 cycles, data_write_enable once, regfile write next cycle, total 8.
// TIMEOUT_CYCLES=4, fetch never ready -> trap=1 after 4 FETCH cycles, trap_cause=2; trap_clear -> FETCH, cause=0.
// mem_ready at exactly counter==TIMEOUT_CYCLES-1 on sw -> write completes, no trap; TIMEOUT_CYCLES=0, 100-cycle wait -> no trap.
// opcode 7'b1110011 -> TRAP cause=1, no enables; beq with take_branch 0/1 -> pc_write_enable 0/1 in BRANCH.
// reset_n low mid MEM_WR -> mem_write_enable falls without clock edge; after release first state FETCH.

Source files
------------

// File: rtl/multicycle_control_hs.sv
// Multicycle RV32I control FSM with a ready/valid memory handshake, bus timeout and trap state.
// Datapath enables and selects are decoded from the state, gated by mem_ready and take_branch.
module multicycle_control_hs #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [6:0] inst_opcode,
   input  logic       take_branch,
   input  logic       mem_ready,
   input  logic       trap_clear,
   output logic       pc_write_enable,
   output logic       inst_write_enable,
   output logic       data_write_enable,
   output logic       alu_out_write_enable,
   output logic       regfile_write_enable,
   output logic       mem_read_enable,
   output logic       mem_write_enable,
   output logic       inst_or_data,
   output logic       alu_operand_a_select,
   output logic [1:0] alu_operand_b_select,
   output logic [1:0] alu_op_type,
   output logic [2:0] reg_writeback_select,
   output logic       next_pc_select,
   output logic       trap,
   output logic [1:0] trap_cause
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic             TO_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WR,
      S_LOAD_WB,
      S_EXEC,
      S_ALU_WB,
      S_BRANCH,
      S_JAL,
      S_JALR,
      S_TRAP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cause_q, cause_d;
   logic             access;
   logic             timeout_hit;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d              = state_q;
      cause_d              = cause_q;
      access               = 1'b0;
      timeout_hit          = TO_EN && (cnt_q == CNT_LAST);
      pc_write_enable      = 1'b0;
      inst_write_enable    = 1'b0;
      data_write_enable    = 1'b0;
      alu_out_write_enable = 1'b0;
      regfile_write_enable = 1'b0;
      mem_read_enable      = 1'b0;
      mem_write_enable     = 1'b0;
      inst_or_data         = 1'b0;
      alu_operand_a_select = 1'b0;
      alu_operand_b_select = 2'd0;
      alu_op_type          = 2'd0;
      reg_writeback_select = 3'd0;
      next_pc_select       = 1'b0;
      trap                 = 1'b0;
      trap_cause           = 2'd0;

      // Outputs are forced idle while reset_n is low so requests drop without a clock edge.
      if (reset_n) begin
         trap_cause = cause_q;
         case (state_q)
            S_FETCH: begin
               mem_read_enable = 1'b1;
               access          = 1'b1;
               if (mem_ready) begin
                  inst_write_enable    = 1'b1;
                  pc_write_enable      = 1'b1;
                  alu_operand_a_select = 1'b1;
                  alu_operand_b_select = 2'd2;
                  state_d              = S_DECODE;
               end else if (timeout_hit) begin
                  state_d = S_TRAP;
                  cause_d = 2'd2;
               end
            end
            S_DECODE: begin
               alu_operand_a_select = 1'b1;
               alu_operand_b_select = 2'd1;
               alu_out_write_enable = 1'b1;
               case (inst_opcode)
                  OPC_LOAD, OPC_STORE:                 state_d = S_MEM_ADDR;
                  OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: state_d = S_EXEC;
                  OPC_BRANCH:                          state_d = S_BRANCH;
                  OPC_JAL:                             state_d = S_JAL;
                  OPC_JALR:                            state_d = S_JALR;
                  default: begin
                     state_d = S_TRAP;
                     cause_d = 2'd1;
                  end
               endcase
            end
            S_MEM_ADDR: begin
               alu_operand_b_select = 2'd1;
               alu_out_write_enable = 1'b1;
               state_d = (inst_opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               mem_read_enable = 1'b1;
               inst_or_data    = 1'b1;
               access          = 1'b1;
               if (mem_ready) begin
                  data_write_enable = 1'b1;
                  state_d           = S_LOAD_WB;
               end else if (timeout_hit) begin
                  state_d = S_TRAP;
                  cause_d = 2'd3;
               end
            end
            S_MEM_WR: begin
               mem_write_enable = 1'b1;
               inst_or_data     = 1'b1;
               access           = 1'b1;
               if (mem_ready) begin
                  state_d = S_FETCH;
               end else if (timeout_hit) begin
                  state_d = S_TRAP;
                  cause_d = 2'd3;
               end
            end
            S_LOAD_WB: begin
               regfile_write_enable = 1'b1;
               reg_writeback_select = 3'd1;
               state_d              = S_FETCH;
            end
            S_EXEC: begin
               alu_out_write_enable = 1'b1;
               case (inst_opcode)
                  OPC_OP: begin
                     alu_operand_b_select = 2'd0;
                     alu_op_type          = 2'd2;
                  end
                  OPC_OPIMM: begin
                     alu_operand_b_select = 2'd1;
                     alu_op_type          = 2'd3;
                  end
                  OPC_AUIPC: begin
                     alu_operand_a_select = 1'b1;
                     alu_operand_b_select = 2'd1;
                  end
                  default: ;
               endcase
               state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
               regfile_write_enable = 1'b1;
               reg_writeback_select = (inst_opcode == OPC_LUI) ? 3'd2 : 3'd0;
               state_d              = S_FETCH;
            end
            S_BRANCH: begin
               alu_op_type     = 2'd1;
               pc_write_enable = take_branch;
               next_pc_select  = 1'b1;
               state_d         = S_FETCH;
            end
            S_JAL: begin
               regfile_write_enable = 1'b1;
               reg_writeback_select = 3'd3;
               pc_write_enable      = 1'b1;
               next_pc_select       = 1'b1;
               state_d              = S_FETCH;
            end
            S_JALR: begin
               alu_operand_b_select = 2'd1;
               regfile_write_enable = 1'b1;
               reg_writeback_select = 3'd3;
               pc_write_enable      = 1'b1;
               state_d              = S_FETCH;
            end
            S_TRAP: begin
               trap = 1'b1;
               if (trap_clear) begin
                  state_d = S_FETCH;
                  cause_d = 2'd0;
               end
            end
            default: state_d = S_FETCH;
         endcase
      end

      // Counter restarts on any state change or completed access and saturates instead of wrapping.
      if ((state_d != state_q) || mem_ready || !access) begin
         cnt_d = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

endmodule

// File: tb/tb_multicycle_control_hs.sv
// Self-checking bench: per-instruction expected cycle traces built from the instruction class
// and the chosen memory wait counts, compared cycle by cycle against the DUT outputs.
module tb_multicycle_control_hs;

   typedef struct packed {
      logic       pc_we;
      logic       ir_we;
      logic       dr_we;
      logic       ao_we;
      logic       rf_we;
      logic       mrd;
      logic       mwr;
      logic       iord;
      logic       asel;
      logic [1:0] bsel;
      logic [1:0] op;
      logic [2:0] wb;
      logic       npc;
      logic       trap;
      logic [1:0] cause;
   } outs_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [6:0] inst_opcode;
   logic       take_branch;
   logic       mem_ready;
   logic       trap_clear;
   outs_t      obs4, obs0;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         tmo      = 4;
   bit         sel      = 1'b0;
   logic [6:0] cur_opc;
   int         cyc      = 0;

   outs_t      q_exp[$];
   bit         q_rdy[$];
   bit         q_tb[$];
   bit         q_clr[$];
   string      q_ph[$];

   always #5 clock = ~clock;

   multicycle_control_hs #(.TIMEOUT_CYCLES(4)) u_dut4 (
      .clock(clock), .reset_n(reset_n), .inst_opcode(inst_opcode),
      .take_branch(take_branch), .mem_ready(mem_ready), .trap_clear(trap_clear),
      .pc_write_enable(obs4.pc_we), .inst_write_enable(obs4.ir_we),
      .data_write_enable(obs4.dr_we), .alu_out_write_enable(obs4.ao_we),
      .regfile_write_enable(obs4.rf_we), .mem_read_enable(obs4.mrd),
      .mem_write_enable(obs4.mwr), .inst_or_data(obs4.iord),
      .alu_operand_a_select(obs4.asel), .alu_operand_b_select(obs4.bsel),
      .alu_op_type(obs4.op), .reg_writeback_select(obs4.wb),
      .next_pc_select(obs4.npc), .trap(obs4.trap), .trap_cause(obs4.cause)
   );

   multicycle_control_hs #(.TIMEOUT_CYCLES(0)) u_dut0 (
      .clock(clock), .reset_n(reset_n), .inst_opcode(inst_opcode),
      .take_branch(take_branch), .mem_ready(mem_ready), .trap_clear(trap_clear),
      .pc_write_enable(obs0.pc_we), .inst_write_enable(obs0.ir_we),
      .data_write_enable(obs0.dr_we), .alu_out_write_enable(obs0.ao_we),
      .regfile_write_enable(obs0.rf_we), .mem_read_enable(obs0.mrd),
      .mem_write_enable(obs0.mwr), .inst_or_data(obs0.iord),
      .alu_operand_a_select(obs0.asel), .alu_operand_b_select(obs0.bsel),
      .alu_op_type(obs0.op), .reg_writeback_select(obs0.wb),
      .next_pc_select(obs0.npc), .trap(obs0.trap), .trap_cause(obs0.cause)
   );

   task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
      end
   endtask

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit is_legal(input logic [6:0] o);
      return o == OPC_LOAD || o == OPC_STORE || o == OPC_OP || o == OPC_OPIMM ||
             o == OPC_LUI || o == OPC_AUIPC || o == OPC_BRANCH || o == OPC_JAL || o == OPC_JALR;
   endfunction

   task automatic push(input bit rdy, input bit tb, input bit clr, input outs_t e, input string ph);
      q_rdy.push_back(rdy);
      q_tb.push_back(tb);
      q_clr.push_back(clr);
      q_exp.push_back(e);
      q_ph.push_back(ph);
   endtask

   // kind: 0 = instruction fetch, 1 = data read, 2 = data write
   task automatic access(input int kind, input int waits, output bit trapped);
      outs_t e;
      bit    done;
      trapped = 1'b0;
      done    = 1'b0;
      for (int k = 0; k <= waits && !done; k++) begin
         bit rdy;
         rdy = (k == waits);
         e = '0;
         if (kind == 2) e.mwr = 1'b1;
         else           e.mrd = 1'b1;
         e.iord = (kind != 0);
         if (rdy && kind == 0) begin
            e.ir_we = 1'b1; e.pc_we = 1'b1; e.asel = 1'b1; e.bsel = 2'd2;
         end
         if (rdy && kind == 1) e.dr_we = 1'b1;
         push(rdy, rb(), rb(), e, (kind == 0) ? "FETCH" : (kind == 1) ? "MEM_RD" : "MEM_WR");
         if (!rdy && tmo > 0 && k == tmo - 1) begin
            trapped = 1'b1;
            done    = 1'b1;
         end
      end
   endtask

   task automatic trap_seq(input logic [1:0] cause);
      outs_t e;
      int    h;
      e = '0; e.trap = 1'b1; e.cause = cause;
      h = $urandom_range(1, 3);
      for (int i = 0; i < h; i++) push(rb(), rb(), 1'b0, e, "TRAP");
      push(rb(), rb(), 1'b1, e, "TRAP_CLR");
   endtask

   task automatic gen_instr(input logic [6:0] opc, input int wf, input int wm, input int tbv);
      outs_t e;
      bit    tr, t;
      cur_opc = opc;
      access(0, wf, tr);
      if (tr) begin
         trap_seq(2'd2);
         return;
      end
      e = '0; e.asel = 1'b1; e.bsel = 2'd1; e.ao_we = 1'b1;
      push(rb(), rb(), rb(), e, "DECODE");
      case (opc)
         OPC_LOAD, OPC_STORE: begin
            e = '0; e.bsel = 2'd1; e.ao_we = 1'b1;
            push(rb(), rb(), rb(), e, "MEM_ADDR");
            access((opc == OPC_LOAD) ? 1 : 2, wm, tr);
            if (tr) trap_seq(2'd3);
            else if (opc == OPC_LOAD) begin
               e = '0; e.rf_we = 1'b1; e.wb = 3'd1;
               push(rb(), rb(), rb(), e, "LOAD_WB");
            end
         end
         OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
            e = '0; e.ao_we = 1'b1;
            if (opc == OPC_OP)    begin e.bsel = 2'd0; e.op = 2'd2; end
            if (opc == OPC_OPIMM) begin e.bsel = 2'd1; e.op = 2'd3; end
            if (opc == OPC_AUIPC) begin e.asel = 1'b1; e.bsel = 2'd1; end
            push(rb(), rb(), rb(), e, "EXEC");
            e = '0; e.rf_we = 1'b1; e.wb = (opc == OPC_LUI) ? 3'd2 : 3'd0;
            push(rb(), rb(), rb(), e, "ALU_WB");
         end
         OPC_BRANCH: begin
            t = (tbv < 0) ? rb() : tbv[0];
            e = '0; e.op = 2'd1; e.npc = 1'b1; e.pc_we = t;
            push(rb(), t, rb(), e, "BRANCH");
         end
         OPC_JAL: begin
            e = '0; e.rf_we = 1'b1; e.wb = 3'd3; e.pc_we = 1'b1; e.npc = 1'b1;
            push(rb(), rb(), rb(), e, "JAL");
         end
         OPC_JALR: begin
            e = '0; e.bsel = 2'd1; e.rf_we = 1'b1; e.wb = 3'd3; e.pc_we = 1'b1;
            push(rb(), rb(), rb(), e, "JALR");
         end
         default: trap_seq(2'd1);
      endcase
   endtask

   task automatic clear_q();
      q_exp.delete(); q_rdy.delete(); q_tb.delete(); q_clr.delete(); q_ph.delete();
   endtask

   // Entered shortly after a falling edge; each step drives, checks, then waits for the next falling edge.
   task automatic run(input int maxn);
      int n;
      n = 0;
      while (q_exp.size() > 0 && n < maxn) begin
         outs_t e;
         string ph;
         inst_opcode = cur_opc;
         mem_ready   = q_rdy.pop_front();
         take_branch = q_tb.pop_front();
         trap_clear  = q_clr.pop_front();
         e  = q_exp.pop_front();
         ph = q_ph.pop_front();
         #1;
         check_eq($sformatf("%s op=%07b cyc=%0d", ph, cur_opc, cyc), sel ? obs0 : obs4, e);
         cyc++;
         n++;
         @(negedge clock);
      end
   endtask

   task automatic do_instr(input logic [6:0] opc, input int wf, input int wm, input int tbv);
      clear_q();
      gen_instr(opc, wf, wm, tbv);
      run(100000);
   endtask

   function automatic logic [6:0] rand_opc();
      logic [6:0] o;
      int         r;
      r = $urandom_range(0, 9);
      case (r)
         0: o = OPC_LOAD;   1: o = OPC_STORE; 2: o = OPC_OP;   3: o = OPC_OPIMM;
         4: o = OPC_LUI;    5: o = OPC_AUIPC; 6: o = OPC_BRANCH; 7: o = OPC_JAL;
         8: o = OPC_JALR;
         default: begin
            o = 7'b1110011;
            for (int i = 0; i < 10; i++) begin
               logic [6:0] c;
               c = 7'($urandom_range(0, 127));
               if (!is_legal(c)) o = c;
            end
         end
      endcase
      return o;
   endfunction

   function automatic int rand_wait(input int lo_max, input int hi_max);
      return ($urandom_range(0, 4) == 0) ? $urandom_range(lo_max + 1, hi_max) : $urandom_range(0, lo_max);
   endfunction

   task automatic reset_pulse();
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      #1;
      check_eq("reset_idle_t4", obs4, '0);
      check_eq("reset_idle_t0", obs0, '0);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n     = 1'b0;
      inst_opcode = '0;
      take_branch = 1'b0;
      mem_ready   = 1'b0;
      trap_clear  = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      check_eq("reset_idle_t4", obs4, '0);
      check_eq("reset_idle_t0", obs0, '0);
      reset_n = 1'b1;

      sel = 1'b0;
      tmo = 4;
      do_instr(OPC_OPIMM, 0, 0, -1);   // addi zero-wait
      do_instr(OPC_LOAD, 0, 3, -1);    // lw with 3 wait states
      do_instr(OPC_OPIMM, 10, 0, -1);  // fetch never ready -> timeout trap
      do_instr(OPC_STORE, 0, 3, -1);   // ready on the last allowed cycle
      do_instr(OPC_LOAD, 0, 4, -1);    // data read timeout
      do_instr(7'b1110011, 0, 0, -1);  // illegal opcode
      do_instr(OPC_BRANCH, 0, 0, 0);
      do_instr(OPC_BRANCH, 0, 0, 1);
      do_instr(OPC_LUI, 1, 0, -1);
      do_instr(OPC_JAL, 0, 0, -1);
      do_instr(OPC_JALR, 2, 0, -1);

      // Reset asserted mid MEM_WR: the write request must drop with no clock edge.
      clear_q();
      gen_instr(OPC_STORE, 0, 3, -1);
      run(4);
      clear_q();
      mem_ready = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("reset_mid_mem_wr", obs4, '0);
      @(negedge clock);
      reset_n = 1'b1;
      do_instr(OPC_OPIMM, 0, 0, -1);

      for (int i = 0; i < 300; i++) begin
         do_instr(rand_opc(), rand_wait(2, 6), rand_wait(2, 6), -1);
      end

      reset_pulse();
      sel = 1'b1;
      tmo = 0;
      do_instr(OPC_OPIMM, 100, 0, -1); // no timeout when disabled
      do_instr(OPC_LOAD, 0, 100, -1);
      do_instr(OPC_STORE, 0, 20, -1);
      for (int i = 0; i < 60; i++) begin
         do_instr(rand_opc(), rand_wait(2, 9), rand_wait(2, 9), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
